// File: rtl/modulo_arbitro_buffer_rolhas_pkg.sv
// Shared constants, state codes and elaboration helpers for the cork buffer arbiter.
// The display encoders and the filling FSM use the same capacities and state codes.
package modulo_arbitro_buffer_rolhas_pkg;

  localparam int W_SEC_DEF        = 7;
  localparam int W_PRI_DEF        = 5;
  localparam int MAX_SEC_DEF      = 99;
  localparam int MAX_PRI_DEF      = 31;
  localparam int TRANSFER_QTY_DEF = 20;
  localparam int MIN_PRI_DEF      = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_TRANSFER = 2'b01,
    ST_LOAD     = 2'b10,
    ST_DONE     = 2'b11
  } estado_t;

  // A transfer that starts at the low-water mark must never overflow the main buffer.
  function automatic bit transfer_cabe(input int min_pri, input int qty, input int max_pri);
    return (min_pri + qty) <= max_pri;
  endfunction

  function automatic bit capacidade_cabe(input int max_val, input int width);
    return (max_val >= 1) && (max_val < (1 << width));
  endfunction

endpackage

// File: rtl/modulo_arbitro_buffer_rolhas_passos.sv
// Loadable step down-counter pacing TRANSFER and LOAD moves.
// 'last' marks the final step so the mover leaves on the cycle the count reaches zero.
module modulo_contador_passos #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (en && (count_reg != '0)) begin
      count_next = count_reg - W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);
  assign last = (count_reg == W'(1));

endmodule

// File: rtl/modulo_arbitro_buffer_rolhas.sv
// Single owner of the secondary (operator refill) and main (sealer) cork counts.
// Grants one mover at a time and applies sealing consumption in every state.
module modulo_arbitro_buffer_rolhas
  import modulo_arbitro_buffer_rolhas_pkg::*;
#(
  parameter int W_SEC        = W_SEC_DEF,
  parameter int W_PRI        = W_PRI_DEF,
  parameter int MAX_SEC      = MAX_SEC_DEF,
  parameter int MAX_PRI      = MAX_PRI_DEF,
  parameter int TRANSFER_QTY = TRANSFER_QTY_DEF,
  parameter int MIN_PRI      = MIN_PRI_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic             seal_pulse,
  input  logic             op_req,
  input  logic [W_SEC-1:0] op_qty,
  output logic             op_ack,
  output logic             op_reject,
  output logic [W_SEC-1:0] sec_count,
  output logic [W_PRI-1:0] pri_count,
  output logic             busy,
  output logic             xfer_active,
  output logic             ro,
  output logic             seal_err,
  output logic [1:0]       state
);

  if (!transfer_cabe(MIN_PRI, TRANSFER_QTY, MAX_PRI)) begin : g_chk_transfer
    $error("MIN_PRI + TRANSFER_QTY exceeds MAX_PRI");
  end
  if (!capacidade_cabe(MAX_SEC, W_SEC) || !capacidade_cabe(MAX_PRI, W_PRI)) begin : g_chk_width
    $error("capacity does not fit its counter width");
  end
  if (TRANSFER_QTY < 1 || TRANSFER_QTY > MAX_SEC) begin : g_chk_qty
    $error("TRANSFER_QTY out of range");
  end

  localparam logic [W_SEC-1:0] XFER_QTY_V = W_SEC'(TRANSFER_QTY);
  localparam logic [W_PRI-1:0] MIN_PRI_V  = W_PRI'(MIN_PRI);
  localparam logic [W_SEC:0]   MAX_SEC_W  = (W_SEC+1)'(MAX_SEC);

  estado_t          state_reg, state_next;
  logic [W_SEC-1:0] sec_reg, sec_next;
  logic [W_PRI-1:0] pri_reg, pri_next;
  logic             cd_reg, cd_next;

  logic             step_load, step_en, step_zero, step_last;
  logic [W_SEC-1:0] step_load_val;

  logic             xfer_cond, op_fits;
  logic [W_SEC:0]   sec_sum;
  logic             sec_inc, sec_dec, pri_inc, seal_take;
  logic             ack_int, reject_int;

  modulo_contador_passos #(.W(W_SEC)) u_passos (
    .clk      (clk),
    .clr      (clr),
    .load     (step_load),
    .en       (step_en),
    .load_val (step_load_val),
    .zero     (step_zero),
    .last     (step_last)
  );

  // Sum is one bit wider so offers that would exceed the display limit are caught, not wrapped.
  assign sec_sum   = {1'b0, sec_reg} + {1'b0, op_qty};
  assign op_fits   = (op_qty != '0) && (sec_sum <= MAX_SEC_W);
  assign xfer_cond = (pri_reg <= MIN_PRI_V) && (sec_reg >= XFER_QTY_V);
  assign seal_take = seal_pulse && (pri_reg != '0);

  always_comb begin
    state_next    = state_reg;
    cd_next       = 1'b0;
    ack_int       = 1'b0;
    reject_int    = 1'b0;
    step_load     = 1'b0;
    step_en       = 1'b0;
    step_load_val = '0;
    sec_inc       = 1'b0;
    sec_dec       = 1'b0;
    pri_inc       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          if (xfer_cond) begin
            state_next    = ST_TRANSFER;
            step_load     = 1'b1;
            step_load_val = XFER_QTY_V;
          end else if (op_req && op_fits) begin
            ack_int       = 1'b1;
            state_next    = ST_LOAD;
            step_load     = 1'b1;
            step_load_val = op_qty;
          end else if (op_req && !cd_reg) begin
            // Cooldown flag halves the reject rate while a refused request is held.
            reject_int = 1'b1;
            cd_next    = 1'b1;
          end
        end
      end
      ST_TRANSFER: begin
        sec_dec = 1'b1;
        pri_inc = 1'b1;
        step_en = 1'b1;
        if (step_last) state_next = ST_DONE;
      end
      ST_LOAD: begin
        sec_inc = 1'b1;
        step_en = 1'b1;
        if (step_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    sec_next = sec_reg;
    if (sec_inc) begin
      sec_next = sec_reg + W_SEC'(1);
    end else if (sec_dec) begin
      sec_next = sec_reg - W_SEC'(1);
    end
  end

  // A transfer step and a seal in the same cycle cancel on the main buffer.
  always_comb begin
    pri_next = pri_reg;
    case ({pri_inc, seal_take})
      2'b10:   pri_next = pri_reg + W_PRI'(1);
      2'b01:   pri_next = pri_reg - W_PRI'(1);
      default: pri_next = pri_reg;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= ST_IDLE;
      sec_reg   <= '0;
      pri_reg   <= '0;
      cd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      sec_reg   <= sec_next;
      pri_reg   <= pri_next;
      cd_reg    <= cd_next;
    end
  end

  // Pulses are forced low while reset is held, even if requests are already present.
  assign op_ack      = clr & ack_int;
  assign op_reject   = clr & reject_int;
  assign seal_err    = clr & seal_pulse & (pri_reg == '0);
  assign sec_count   = sec_reg;
  assign pri_count   = pri_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign xfer_active = (state_reg == ST_TRANSFER);
  assign ro          = (pri_reg == '0);
  assign state       = state_reg;

  a_sec_max: assert property (@(posedge clk) disable iff (!clr) sec_reg <= W_SEC'(MAX_SEC));
  a_pri_max: assert property (@(posedge clk) disable iff (!clr) pri_reg <= W_PRI'(MAX_PRI));
  a_ack_rej: assert property (@(posedge clk) disable iff (!clr) !(op_ack && op_reject));
  a_ack_load: assert property (@(posedge clk) disable iff (!clr) op_ack |=> (state_reg == ST_LOAD));
  a_step_live: assert property (@(posedge clk) disable iff (!clr)
                 (state_reg == ST_TRANSFER || state_reg == ST_LOAD) |-> !step_zero);

endmodule

// File: tb/tb_modulo_arbitro_buffer_rolhas.sv
// Directed scenarios plus randomized traffic against a cycle-level buffer model.
module tb_modulo_arbitro_buffer_rolhas;

  localparam int MAX_SEC = 99;
  localparam int TQ      = 20;
  localparam int MIN_PRI = 5;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       enable = 1'b0;
  logic       seal_pulse = 1'b0;
  logic       op_req = 1'b0;
  logic [6:0] op_qty = '0;
  logic       op_ack, op_reject, busy, xfer_active, ro, seal_err;
  logic [6:0] sec_count;
  logic [4:0] pri_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 transfer, 2 load, 3 done; rem = moves left
  int m_mode, m_rem, m_sec, m_pri;
  bit m_cd;

  logic       o_ack, o_rej, o_serr, o_busy, o_xfer, o_ro;
  logic [1:0] o_state;
  logic [6:0] o_sec;
  logic [4:0] o_pri;
  bit         e_ack, e_rej, e_serr;
  int         e_state, e_sec, e_pri;

  modulo_arbitro_buffer_rolhas dut (
    .clk         (clk),
    .clr         (clr),
    .enable      (enable),
    .seal_pulse  (seal_pulse),
    .op_req      (op_req),
    .op_qty      (op_qty),
    .op_ack      (op_ack),
    .op_reject   (op_reject),
    .sec_count   (sec_count),
    .pri_count   (pri_count),
    .busy        (busy),
    .xfer_active (xfer_active),
    .ro          (ro),
    .seal_err    (seal_err),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_mode = 0; m_rem = 0; m_sec = 0; m_pri = 0; m_cd = 1'b0;
  endtask

  // One clock: sample DUT and model expectations at negedge, then advance the model.
  task automatic tick();
    int n_mode, n_rem, n_sec, n_pri;
    bit n_cd, xc, fits;
    @(negedge clk);
    o_ack = op_ack; o_rej = op_reject; o_serr = seal_err; o_busy = busy;
    o_xfer = xfer_active; o_ro = ro; o_state = state; o_sec = sec_count; o_pri = pri_count;
    e_state = m_mode; e_sec = m_sec; e_pri = m_pri;
    e_serr = seal_pulse && (m_pri == 0);
    e_ack = 1'b0; e_rej = 1'b0;
    n_mode = m_mode; n_rem = m_rem; n_sec = m_sec; n_pri = m_pri; n_cd = 1'b0;
    xc   = (m_pri <= MIN_PRI) && (m_sec >= TQ);
    fits = (op_qty != 0) && (m_sec + int'(op_qty) <= MAX_SEC);
    case (m_mode)
      0: if (enable) begin
        if (xc) begin
          n_mode = 1; n_rem = TQ;
        end else if (op_req && fits) begin
          e_ack = 1'b1; n_mode = 2; n_rem = int'(op_qty);
        end else if (op_req && !m_cd) begin
          e_rej = 1'b1; n_cd = 1'b1;
        end
      end
      1: begin
        n_sec = m_sec - 1; n_pri = m_pri + 1; n_rem = m_rem - 1;
        if (n_rem == 0) n_mode = 3;
      end
      2: begin
        n_sec = m_sec + 1; n_rem = m_rem - 1;
        if (n_rem == 0) n_mode = 3;
      end
      default: n_mode = 0;
    endcase
    if (seal_pulse && m_pri > 0) n_pri = n_pri - 1;
    @(posedge clk);
    #1;
    m_mode = n_mode; m_rem = n_rem; m_sec = n_sec; m_pri = n_pri; m_cd = n_cd;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    clr = 1'b0; op_req = 1'b0; seal_pulse = 1'b0; enable = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    enable = 1'b1; op_req = 1'b1; op_qty = 7'd30; seal_pulse = 1'b1;
    #1 clr = 1'b0;
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (sec_count !== 7'd0 || pri_count !== 5'd0) begin errors++;
      $display("FAIL reset_counts got sec=%0d pri=%0d want 0/0", sec_count, pri_count); end
    checks++; if (ro !== 1'b1 || busy !== 1'b0 || xfer_active !== 1'b0) begin errors++;
      $display("FAIL reset_flags got ro=%0b busy=%0b xfer=%0b want 1/0/0", ro, busy, xfer_active); end
    @(posedge clk);
    #1;
    checks++; if (op_ack !== 1'b0 || op_reject !== 1'b0 || seal_err !== 1'b0) begin errors++;
      $display("FAIL reset_pulses got ack=%0b rej=%0b serr=%0b want 0/0/0", op_ack, op_reject, seal_err); end
    seal_pulse = 1'b0; op_req = 1'b0;
    clr = 1'b1;
    model_clear();
  endtask

  task automatic test_load_from_reset();
    int n_load;
    enable = 1'b1; op_req = 1'b1; op_qty = 7'd30;
    tick();
    checks++; if (o_ack !== 1'b1 || o_state !== 2'd0) begin errors++;
      $display("FAIL load_ack got ack=%0b state=%0d want 1/0", o_ack, o_state); end
    op_req = 1'b0;
    n_load = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_state == 2'd2) n_load++;
    end
    checks++; if (n_load != 30) begin errors++; $display("FAIL load_cycles got %0d want 30", n_load); end
    tick();
    checks++; if (o_state !== 2'd3 || o_sec !== 7'd30) begin errors++;
      $display("FAIL load_done got state=%0d sec=%0d want 3/30", o_state, o_sec); end
    tick();
    checks++; if (o_state !== 2'd0 || o_pri !== 5'd0 || o_ro !== 1'b1) begin errors++;
      $display("FAIL load_idle got state=%0d pri=%0d ro=%0b want 0/0/1", o_state, o_pri, o_ro); end
  endtask

  task automatic test_transfer();
    int n_x;
    n_x = 0;
    for (int i = 0; i < TQ; i++) begin
      tick();
      if (o_xfer === 1'b1) n_x++;
      if (i == 0) begin
        checks++; if (o_ro !== 1'b1) begin errors++; $display("FAIL xfer_ro_first got %0b want 1", o_ro); end
      end
      if (i == 1) begin
        checks++; if (o_ro !== 1'b0) begin errors++; $display("FAIL xfer_ro_second got %0b want 0", o_ro); end
      end
    end
    checks++; if (n_x != TQ) begin errors++; $display("FAIL xfer_cycles got %0d want %0d", n_x, TQ); end
    tick();
    checks++; if (o_state !== 2'd3 || o_sec !== 7'd10 || o_pri !== 5'd20 || o_xfer !== 1'b0) begin errors++;
      $display("FAIL xfer_result got state=%0d sec=%0d pri=%0d xfer=%0b want 3/10/20/0", o_state, o_sec, o_pri, o_xfer); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1; op_req = 1'b1; op_qty = 7'd95;
    tick(); op_req = 1'b0;
    run(96);
    run(22);
    op_req = 1'b1; op_qty = 7'd20;
    tick(); op_req = 1'b0;
    run(21);
    op_req = 1'b1; op_qty = 7'd5;
    tick();
    checks++; if (o_rej !== 1'b1 || o_ack !== 1'b0 || o_sec !== 7'd95) begin errors++;
      $display("FAIL ovf_reject got rej=%0b ack=%0b sec=%0d want 1/0/95", o_rej, o_ack, o_sec); end
    tick();
    checks++; if (o_rej !== 1'b0) begin errors++; $display("FAIL ovf_cooldown got %0b want 0", o_rej); end
    tick();
    checks++; if (o_rej !== 1'b1) begin errors++; $display("FAIL ovf_repulse got %0b want 1", o_rej); end
    op_qty = 7'd4;
    tick();
    checks++; if (o_ack !== 1'b1 || o_rej !== 1'b0) begin errors++;
      $display("FAIL ovf_ack got ack=%0b rej=%0b want 1/0", o_ack, o_rej); end
    op_req = 1'b0;
    run(5);
    tick();
    checks++; if (o_sec !== 7'd99 || o_state !== 2'd0) begin errors++;
      $display("FAIL ovf_full got sec=%0d state=%0d want 99/0", o_sec, o_state); end
  endtask

  task automatic test_priority();
    int n_ack;
    do_reset();
    enable = 1'b1; op_req = 1'b1; op_qty = 7'd40;
    tick(); op_req = 1'b0;
    run(41);
    run(22);
    op_req = 1'b1; op_qty = 7'd20;
    tick(); op_req = 1'b0;
    run(21);
    enable = 1'b0; seal_pulse = 1'b1;
    run(15);
    seal_pulse = 1'b0;
    enable = 1'b1; op_req = 1'b1; op_qty = 7'd10;
    tick();
    checks++; if (o_pri !== 5'd5 || o_sec !== 7'd40 || o_ack !== 1'b0 || o_rej !== 1'b0) begin errors++;
      $display("FAIL prio_start got pri=%0d sec=%0d ack=%0b rej=%0b want 5/40/0/0", o_pri, o_sec, o_ack, o_rej); end
    n_ack = 0;
    for (int i = 0; i < TQ + 1; i++) begin
      tick();
      if (o_ack === 1'b1) n_ack++;
    end
    checks++; if (n_ack != 0 || o_pri !== 5'd25 || o_sec !== 7'd20) begin errors++;
      $display("FAIL prio_xfer got acks=%0d pri=%0d sec=%0d want 0/25/20", n_ack, o_pri, o_sec); end
    tick();
    checks++; if (o_ack !== 1'b1) begin errors++; $display("FAIL prio_late_ack got %0b want 1", o_ack); end
    op_req = 1'b0;
    run(11);
    tick();
    checks++; if (o_sec !== 7'd30) begin errors++; $display("FAIL prio_final got sec=%0d want 30", o_sec); end
  endtask

  task automatic test_seal();
    int n_err;
    enable = 1'b0; seal_pulse = 1'b1;
    run(22);
    seal_pulse = 1'b0; enable = 1'b1;
    tick();
    seal_pulse = 1'b1;
    n_err = 0;
    for (int i = 0; i < TQ; i++) begin
      tick();
      if (o_serr === 1'b1 || o_pri !== 5'd3) n_err++;
    end
    checks++; if (n_err != 0) begin errors++; $display("FAIL seal_xfer got %0d bad cycles want 0", n_err); end
    seal_pulse = 1'b0;
    tick();
    checks++; if (o_pri !== 5'd3 || o_sec !== 7'd10) begin errors++;
      $display("FAIL seal_net got pri=%0d sec=%0d want 3/10", o_pri, o_sec); end
    enable = 1'b0; seal_pulse = 1'b1;
    run(3);
    tick();
    checks++; if (o_serr !== 1'b1 || o_pri !== 5'd0) begin errors++;
      $display("FAIL seal_empty got serr=%0b pri=%0d want 1/0", o_serr, o_pri); end
    seal_pulse = 1'b0;
    tick();
    checks++; if (o_serr !== 1'b0 || o_pri !== 5'd0) begin errors++;
      $display("FAIL seal_after got serr=%0b pri=%0d want 0/0", o_serr, o_pri); end
  endtask

  task automatic test_async_and_enable();
    int n_busy;
    do_reset();
    enable = 1'b1; op_req = 1'b1; op_qty = 7'd20;
    tick(); op_req = 1'b0;
    run(13);
    #3 clr = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || sec_count !== 7'd0 || pri_count !== 5'd0 || busy !== 1'b0) begin errors++;
      $display("FAIL async_clr got state=%0d sec=%0d pri=%0d busy=%0b want 0/0/0/0", state, sec_count, pri_count, busy); end
    @(posedge clk);
    #1;
    clr = 1'b1;
    model_clear();
    enable = 1'b1; op_req = 1'b1; op_qty = 7'd50;
    tick(); op_req = 1'b0;
    run(10);
    enable = 1'b0;
    run(41);
    n_busy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_state !== 2'd0) n_busy++;
    end
    checks++; if (n_busy != 0 || o_sec !== 7'd50 || o_pri !== 5'd0) begin errors++;
      $display("FAIL enable_hold got busy=%0d sec=%0d pri=%0d want 0/50/0", n_busy, o_sec, o_pri); end
    enable = 1'b1;
    tick();
    tick();
    checks++; if (o_state !== 2'd1 || o_xfer !== 1'b1) begin errors++;
      $display("FAIL enable_xfer got state=%0d xfer=%0b want 1/1", o_state, o_xfer); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable = (($urandom % 16) != 0);
      seal_pulse = (($urandom % 3) == 0);
      if (!op_req && (($urandom % 4) == 0)) begin
        op_req = 1'b1;
        op_qty = 7'($urandom_range(0, 60));
      end
      tick();
      checks++; if (o_state !== e_state[1:0]) begin errors++; $display("FAIL rnd_state c%0d got %0d want %0d", i, o_state, e_state); end
      checks++; if (o_sec !== e_sec[6:0]) begin errors++; $display("FAIL rnd_sec c%0d got %0d want %0d", i, o_sec, e_sec); end
      checks++; if (o_pri !== e_pri[4:0]) begin errors++; $display("FAIL rnd_pri c%0d got %0d want %0d", i, o_pri, e_pri); end
      checks++; if (o_ack !== e_ack || o_rej !== e_rej) begin errors++;
        $display("FAIL rnd_grant c%0d got ack=%0b rej=%0b want %0b/%0b", i, o_ack, o_rej, e_ack, e_rej); end
      checks++; if (o_serr !== e_serr || o_ro !== (e_pri == 0)) begin errors++;
        $display("FAIL rnd_flags c%0d got serr=%0b ro=%0b want %0b/%0b", i, o_serr, o_ro, e_serr, (e_pri == 0)); end
      checks++; if (o_busy !== (e_state != 0) || o_xfer !== (e_state == 1)) begin errors++;
        $display("FAIL rnd_status c%0d got busy=%0b xfer=%0b want %0b/%0b", i, o_busy, o_xfer, (e_state != 0), (e_state == 1)); end
      if (o_ack === 1'b1) op_req = 1'b0;
      else if (o_rej === 1'b1 && (($urandom % 2) == 0)) op_req = 1'b0;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_from_reset();
    test_transfer();
    test_overflow();
    test_priority();
    test_seal();
    test_async_and_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
